// File: rtl/arm_lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, fault codes,
// FSM state encoding and the big-endian lane shift helper.
package arm_lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   localparam logic [1:0] FLT_NONE  = 2'b00;
   localparam logic [1:0] FLT_ALIGN = 2'b01;
   localparam logic [1:0] FLT_BUS   = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RMW_RD,
      ST_STORE,
      ST_RESP
   } lsu_state_t;

   // Right-shift that brings the addressed big-endian lane down to bit 0.
   function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] a_lo);
      logic [4:0] sh;
      sh = 5'd0;
      if (size == SZ_BYTE)
         sh = {~a_lo, 3'b000};
      else if (size == SZ_HALF)
         sh = {~a_lo[1], 4'b0000};
      return sh;
   endfunction

endpackage

// File: rtl/arm_lsu_lane.sv
// Combinational lane logic: load extract/extend and sub-word store merge
// on a big-endian memory word.
module arm_lsu_lane
   import arm_lsu_pkg::*;
(
   input  logic [1:0]  i_addr_lo,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [31:0] i_mem_rdata,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load_data,
   output logic [31:0] o_merge_data
);

   logic [4:0]  w_shift;
   logic [31:0] w_shifted;
   logic [31:0] w_mask;

   assign w_shift   = lane_shift(i_size, i_addr_lo);
   assign w_shifted = i_mem_rdata >> w_shift;

   always_comb begin
      o_load_data = i_mem_rdata;
      w_mask      = 32'hFFFF_FFFF;
      case (i_size)
         SZ_BYTE: begin
            o_load_data = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
            w_mask      = 32'h0000_00FF << w_shift;
         end
         SZ_HALF: begin
            o_load_data = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
            w_mask      = 32'h0000_FFFF << w_shift;
         end
         default: ;
      endcase
   end

   // Store data is right-justified; move it up into its lane and splice.
   assign o_merge_data = (i_mem_rdata & ~w_mask) | ((i_wdata << w_shift) & w_mask);

endmodule

// File: rtl/arm_lsu.sv
// Load/store unit driving a single big-endian word memory port; sub-word
// stores are done as read-modify-write.
module arm_lsu
   import arm_lsu_pkg::*;
#(
   parameter bit ALIGN_FAULT = 1'b1
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_fault,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic        mem_excpt,
   input  logic [31:0] mem_rdata
);

   lsu_state_t  r_state;
   lsu_state_t  w_state_next;
   logic [1:0]  r_addr_lo;
   logic [1:0]  r_size;
   logic        r_signed;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic [1:0]  r_fault;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;

   logic        w_misaligned;
   logic        w_align_flt;
   logic [31:0] w_acc_addr;
   logic        w_accept;
   logic [31:0] w_load_data;
   logic [31:0] w_merge_data;

   always_comb begin
      w_misaligned = 1'b0;
      w_acc_addr   = req_addr;
      case (req_size)
         SZ_HALF: begin
            w_misaligned = req_addr[0];
            w_acc_addr   = ALIGN_FAULT ? req_addr : {req_addr[31:1], 1'b0};
         end
         SZ_WORD: begin
            w_misaligned = |req_addr[1:0];
            w_acc_addr   = ALIGN_FAULT ? req_addr : {req_addr[31:2], 2'b00};
         end
         default: ;
      endcase
   end

   // The reserved size faults regardless of the alignment policy.
   assign w_align_flt = (req_size == SZ_RSVD) | (ALIGN_FAULT & w_misaligned);
   assign w_accept    = (r_state == ST_IDLE) & req_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               if (w_align_flt)
                  w_state_next = ST_RESP;
               else if (!req_write)
                  w_state_next = ST_LOAD;
               else if (req_size == SZ_WORD)
                  w_state_next = ST_STORE;
               else
                  w_state_next = ST_RMW_RD;
            end
         end
         ST_LOAD:   w_state_next = ST_RESP;
         ST_RMW_RD: w_state_next = mem_excpt ? ST_RESP : ST_STORE;
         ST_STORE:  w_state_next = ST_RESP;
         ST_RESP:   w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   arm_lsu_lane u_lane (
      .i_addr_lo    (r_addr_lo),
      .i_size       (r_size),
      .i_signed     (r_signed),
      .i_mem_rdata  (mem_rdata),
      .i_wdata      (r_wdata),
      .o_load_data  (w_load_data),
      .o_merge_data (w_merge_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr_lo   <= 2'b00;
         r_size      <= SZ_BYTE;
         r_signed    <= 1'b0;
         r_wdata     <= 32'd0;
         r_rdata     <= 32'd0;
         r_fault     <= FLT_NONE;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
      end else begin
         if (w_accept) begin
            r_addr_lo <= w_acc_addr[1:0];
            r_size    <= req_size;
            r_signed  <= req_signed;
            r_wdata   <= req_wdata;
            r_rdata   <= 32'd0;
            r_fault   <= w_align_flt ? FLT_ALIGN : FLT_NONE;
            if (!w_align_flt) begin
               r_mem_addr <= {w_acc_addr[31:2], 2'b00};
               if (req_write && req_size == SZ_WORD)
                  r_mem_wdata <= req_wdata;
            end
         end
         case (r_state)
            ST_LOAD: begin
               if (mem_excpt)
                  r_fault <= FLT_BUS;
               else
                  r_rdata <= w_load_data;
            end
            ST_RMW_RD: begin
               if (mem_excpt)
                  r_fault <= FLT_BUS;
               else
                  r_mem_wdata <= w_merge_data;
            end
            ST_STORE: begin
               if (mem_excpt)
                  r_fault <= FLT_BUS;
            end
            default: ;
         endcase
      end
   end

   // Decoded from the async-reset state so mem_we drops the moment rst_n falls.
   assign req_ready  = (r_state == ST_IDLE);
   assign resp_valid = (r_state == ST_RESP);
   assign mem_we     = (r_state == ST_STORE);
   assign resp_rdata = r_rdata;
   assign resp_fault = r_fault;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;

endmodule
